// File: rtl/dmem_pkg.sv
// ============================================================================
// Package : dmem_pkg
// Shared access-size encodings, FSM state type and request snapshot used by
// the two-port data-memory arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  // Access size encodings presented by the requesters
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Arbiter sequencing: accept, perform the DMEM access, then respond
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Snapshot of the accepted request, held for the access and response phases
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sext;
    logic        id;
    logic        err;
  } hold_t;

  // One-hot response strobe for the granted port
  function automatic logic [1:0] port_onehot(input logic id);
    port_onehot = id ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_align_chk.sv
// ============================================================================
// Module  : dmem_align_chk
// Combinational legality check of an access: illegal size encoding always
// faults; misaligned halfword/word accesses fault when alignment checking is
// enabled.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_align_chk
  import dmem_pkg::*;
#(
  parameter int ALIGN_CHK = 1
) (
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic       err_o
);

  localparam logic CHK_ON = (ALIGN_CHK != 0);

  // Decode the fault condition from the size and the two low address bits
  always_comb begin
    err_o = 1'b0;
    case (size_i)
      SZ_HALF: err_o = CHK_ON & addr_lo_i[0];
      SZ_WORD: err_o = CHK_ON & (addr_lo_i != 2'b00);
      SZ_ILL:  err_o = 1'b1;
      default: err_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Two-port arbiter in front of a single combinational-read data memory.
// One access is in flight at a time: accept (IDLE) -> DMEM access (ACCESS)
// -> one-cycle response pulse (RESP). Contention is resolved round-robin or
// by fixed priority (port 0 highest).
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int RR_EN     = 1,
  parameter int ALIGN_CHK = 1
) (
  input  logic        clk,
  input  logic        rst,
  // Requester 0
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  input  logic [1:0]  p0_req_size,
  input  logic        p0_req_sext,
  output logic        p0_resp_valid,
  output logic [31:0] p0_resp_rdata,
  output logic        p0_resp_err,
  // Requester 1
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  input  logic [1:0]  p1_req_size,
  input  logic        p1_req_sext,
  output logic        p1_resp_valid,
  output logic [31:0] p1_resp_rdata,
  output logic        p1_resp_err,
  // Data memory
  output logic        dmem_write_en,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_write_data,
  output logic [1:0]  dmem_size,
  output logic        dmem_sign_extend,
  input  logic [31:0] dmem_read_data
);

  localparam logic RR_ON = (RR_EN != 0);

  state_e      state_q;
  logic        rr_q;          // port preferred on the next contended cycle
  hold_t       hold_q;        // accepted request
  hold_t       hold_d;        // request that would be accepted this cycle
  logic [31:0] rdata_q;       // load data captured at the end of ACCESS
  logic        resp_err_q;
  logic [1:0]  resp_valid_q;  // one-hot response strobe, bit n = port n

  logic        w_sel;         // port selected for a grant this cycle
  logic        w_any_valid;
  logic        w_idle;
  logic        w_handshake;
  logic [1:0]  w_sel_size;
  logic [31:0] w_sel_addr;
  logic        w_err;

  assign w_any_valid = p0_req_valid | p1_req_valid;
  assign w_idle      = (state_q == IDLE) & ~rst;
  assign w_handshake = w_idle & w_any_valid;

  // Pick the port to grant: a lone requester wins; contention follows the
  // round-robin pointer or falls back to port 0
  always_comb begin
    w_sel = 1'b0;
    if (p0_req_valid && p1_req_valid) begin
      w_sel = RR_ON ? rr_q : 1'b0;
    end else if (p1_req_valid) begin
      w_sel = 1'b1;
    end
  end

  // Ready is only offered in IDLE and only to the selected valid port
  assign p0_req_ready = w_idle & p0_req_valid & ~w_sel;
  assign p1_req_ready = w_idle & p1_req_valid &  w_sel;

  assign w_sel_size = w_sel ? p1_req_size : p0_req_size;
  assign w_sel_addr = w_sel ? p1_req_addr : p0_req_addr;

  // Legality is decided once, on the selected request, and latched with it
  dmem_align_chk #(
    .ALIGN_CHK (ALIGN_CHK)
  ) u_align_chk (
    .size_i    (w_sel_size),
    .addr_lo_i (w_sel_addr[1:0]),
    .err_o     (w_err)
  );

  assign hold_d = '{
    we:    (w_sel ? p1_req_we    : p0_req_we),
    addr:  w_sel_addr,
    wdata: (w_sel ? p1_req_wdata : p0_req_wdata),
    size:  w_sel_size,
    sext:  (w_sel ? p1_req_sext  : p0_req_sext),
    id:    w_sel,
    err:   w_err
  };

  // Sequencer: accept, access, respond; also owns the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      hold_q       <= '0;
      rdata_q      <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 2'b00;
          if (w_handshake) begin
            hold_q  <= hold_d;
            // Faulting requests still consume their turn
            rr_q    <= ~w_sel;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q      <= (hold_q.we | hold_q.err) ? 32'h0 : dmem_read_data;
          resp_err_q   <= hold_q.err;
          resp_valid_q <= port_onehot(hold_q.id);
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 2'b00;
          state_q      <= IDLE;
        end
        default: begin
          resp_valid_q <= 2'b00;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // The memory sees the held request at all times; only the strobe is
  // phase-qualified. Reset gates it so a store in flight is dropped.
  assign dmem_write_en    = (state_q == ACCESS) & hold_q.we & ~hold_q.err & ~rst;
  assign dmem_addr        = hold_q.addr;
  assign dmem_write_data  = hold_q.wdata;
  assign dmem_size        = hold_q.size;
  assign dmem_sign_extend = hold_q.sext;

  // Response fields are forced to zero on the port that is not being answered
  assign p0_resp_valid = resp_valid_q[0];
  assign p1_resp_valid = resp_valid_q[1];
  assign p0_resp_err   = resp_valid_q[0] & resp_err_q;
  assign p1_resp_err   = resp_valid_q[1] & resp_err_q;
  assign p0_resp_rdata = resp_valid_q[0] ? rdata_q : 32'h0;
  assign p1_resp_rdata = resp_valid_q[1] ? rdata_q : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module  : tb_dmem_arbiter
// Directed bench for dmem_arbiter with a byte-addressed memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin instance signals
  logic        p0_req_valid, p0_req_we, p0_req_sext;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic [1:0]  p0_req_size;
  logic        p1_req_valid, p1_req_we, p1_req_sext;
  logic [31:0] p1_req_addr, p1_req_wdata;
  logic [1:0]  p1_req_size;
  logic        p0_req_ready, p1_req_ready;
  logic        p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err;
  logic [31:0] p0_resp_rdata, p1_resp_rdata;
  logic        dmem_write_en, dmem_sign_extend;
  logic [31:0] dmem_addr, dmem_write_data, dmem_read_data;
  logic [1:0]  dmem_size;

  // Fixed-priority instance signals
  logic        fp_p0_req_valid, fp_p1_req_valid;
  logic        fp_p0_req_ready, fp_p1_req_ready;
  logic        fp_p0_resp_valid, fp_p1_resp_valid, fp_p0_resp_err, fp_p1_resp_err;
  logic [31:0] fp_p0_resp_rdata, fp_p1_resp_rdata;
  logic        fp_dmem_write_en, fp_dmem_sign_extend;
  logic [31:0] fp_dmem_addr, fp_dmem_write_data;
  logic [1:0]  fp_dmem_size;

  dmem_arbiter #(.RR_EN(1), .ALIGN_CHK(1)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_size(p0_req_size),
    .p0_req_sext(p0_req_sext), .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
    .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_size(p1_req_size),
    .p1_req_sext(p1_req_sext), .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
    .p1_resp_err(p1_resp_err),
    .dmem_write_en(dmem_write_en), .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data),
    .dmem_size(dmem_size), .dmem_sign_extend(dmem_sign_extend), .dmem_read_data(dmem_read_data)
  );

  dmem_arbiter #(.RR_EN(0), .ALIGN_CHK(1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req_valid(fp_p0_req_valid), .p0_req_ready(fp_p0_req_ready), .p0_req_we(1'b0),
    .p0_req_addr(32'h0), .p0_req_wdata(32'h0), .p0_req_size(2'b00),
    .p0_req_sext(1'b0), .p0_resp_valid(fp_p0_resp_valid), .p0_resp_rdata(fp_p0_resp_rdata),
    .p0_resp_err(fp_p0_resp_err),
    .p1_req_valid(fp_p1_req_valid), .p1_req_ready(fp_p1_req_ready), .p1_req_we(1'b0),
    .p1_req_addr(32'h0), .p1_req_wdata(32'h0), .p1_req_size(2'b00),
    .p1_req_sext(1'b0), .p1_resp_valid(fp_p1_resp_valid), .p1_resp_rdata(fp_p1_resp_rdata),
    .p1_resp_err(fp_p1_resp_err),
    .dmem_write_en(fp_dmem_write_en), .dmem_addr(fp_dmem_addr), .dmem_write_data(fp_dmem_write_data),
    .dmem_size(fp_dmem_size), .dmem_sign_extend(fp_dmem_sign_extend), .dmem_read_data(32'h0)
  );

  // ---------------- memory model: 256 bytes, little-endian ----------------
  logic [7:0] mem [0:255];
  logic       mem_clr;
  logic [7:0] ra0, ra1, ra2, ra3, b0, b1, b2, b3;

  always_comb begin
    ra0 = dmem_addr[7:0];
    ra1 = ra0 + 8'd1;
    ra2 = ra0 + 8'd2;
    ra3 = ra0 + 8'd3;
    b0  = mem[ra0];
    b1  = mem[ra1];
    b2  = mem[ra2];
    b3  = mem[ra3];
    case (dmem_size)
      2'b00:   dmem_read_data = dmem_sign_extend ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   dmem_read_data = dmem_sign_extend ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
      default: dmem_read_data = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (dmem_write_en) begin
      mem[ra0] <= dmem_write_data[7:0];
      if (dmem_size != 2'b00) mem[ra1] <= dmem_write_data[15:8];
      if (dmem_size == 2'b10) begin
        mem[ra2] <= dmem_write_data[23:16];
        mem[ra3] <= dmem_write_data[31:24];
      end
    end
  end

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Protocol monitor: one ready per cycle, response on the granted port
  // exactly two cycles after its handshake, grant order log
  logic [1:0] hs_d1 = 2'b00;
  logic [1:0] hs_d2 = 2'b00;
  int viol_ready = 0;
  int viol_resp  = 0;
  int we_seen    = 0;
  int grants[$];

  always @(negedge clk) begin
    logic [1:0] hs;
    hs = {p1_req_valid & p1_req_ready, p0_req_valid & p0_req_ready};
    if (p0_req_ready && p1_req_ready) viol_ready++;
    if ({p1_resp_valid, p0_resp_valid} !== hs_d2) viol_resp++;
    if (dmem_write_en) we_seen++;
    if (hs[0]) grants.push_back(0);
    if (hs[1]) grants.push_back(1);
    if (rst) begin
      hs_d2 = 2'b00;
      hs_d1 = 2'b00;
    end else begin
      hs_d2 = hs_d1;
      hs_d1 = hs;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int port, input logic v, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic sext);
    if (port == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_addr = addr;
      p0_req_wdata = wdata; p0_req_size = size; p0_req_sext = sext;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_addr = addr;
      p1_req_wdata = wdata; p1_req_size = size; p1_req_sext = sext;
    end
  endtask

  function automatic logic port_ready(input int port);
    return (port == 0) ? p0_req_ready : p1_req_ready;
  endfunction

  function automatic logic port_rv(input int port);
    return (port == 0) ? p0_resp_valid : p1_resp_valid;
  endfunction

  // Single access; lat counts negedges from handshake to response
  task automatic xact(input int port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic sext,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(posedge clk); #1;
    drive(port, 1'b1, we, addr, wdata, size, sext);
    n = 0;
    @(negedge clk);
    while (!port_ready(port) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("handshake_timeout", 32'd1, 32'd0);
      drive(port, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      rdata = 32'h0; err = 1'b0; lat = -1;
      return;
    end
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    lat = 1;
    @(negedge clk);
    while (!port_rv(port) && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rdata = (port == 0) ? p0_resp_rdata : p1_resp_rdata;
    err   = (port == 0) ? p0_resp_err   : p1_resp_err;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] rd;
  logic        er;
  int          lat;
  int          snap;
  int          cnt_a, cnt_b;

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    fp_p0_req_valid = 1'b0;
    fp_p1_req_valid = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p0_ready",   {31'h0, p0_req_ready},  32'h0);
    check("rst_resp_valid", {30'h0, p1_resp_valid, p0_resp_valid}, 32'h0);
    check("rst_write_en",   {31'h0, dmem_write_en}, 32'h0);
    check("rst_dmem_addr",  dmem_addr,              32'h0);
    check("rst_rdata",      p0_resp_rdata,          32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_clr = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

    // Byte store then sign-extended byte load
    xact(0, 1'b1, 32'h0, 32'h0000_00AA, 2'b00, 1'b0, rd, er, lat);
    check("sb_err",   {31'h0, er}, 32'h0);
    check("sb_rdata", rd,          32'h0);
    check("sb_lat",   lat,         32'd2);
    xact(0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, rd, er, lat);
    check("lb_sext_rdata", rd,          32'hFFFF_FFAA);
    check("lb_sext_err",   {31'h0, er}, 32'h0);
    check("lb_sext_lat",   lat,         32'd2);

    // Word store, then a misaligned word store from p1 that must not write
    xact(0, 1'b1, 32'h4, 32'h1122_3344, 2'b10, 1'b0, rd, er, lat);
    check("sw_err", {31'h0, er}, 32'h0);
    snap = we_seen;
    xact(1, 1'b1, 32'h6, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, er, lat);
    check("sw_mis_err",   {31'h0, er}, 32'h1);
    check("sw_mis_rdata", rd,          32'h0);
    check("sw_mis_noweN", we_seen - snap, 32'd0);
    xact(1, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, rd, er, lat);
    check("lw_old_rdata", rd,          32'h1122_3344);
    check("lw_old_err",   {31'h0, er}, 32'h0);

    // Halfword store and both load extensions
    xact(0, 1'b1, 32'h4, 32'h0000_BBCC, 2'b01, 1'b0, rd, er, lat);
    check("sh_err", {31'h0, er}, 32'h0);
    xact(0, 1'b0, 32'h4, 32'h0, 2'b01, 1'b0, rd, er, lat);
    check("lh_zext", rd, 32'h0000_BBCC);
    xact(0, 1'b0, 32'h4, 32'h0, 2'b01, 1'b1, rd, er, lat);
    check("lh_sext", rd, 32'hFFFF_BBCC);
    xact(0, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, rd, er, lat);
    check("lw_after_sh", rd, 32'h1122_BBCC);
    xact(1, 1'b0, 32'h5, 32'h0, 2'b01, 1'b0, rd, er, lat);
    check("lh_mis_err", {31'h0, er}, 32'h1);

    // Illegal size
    xact(0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, rd, er, lat);
    check("sz11_err",   {31'h0, er}, 32'h1);
    check("sz11_rdata", rd,          32'h0);

    // Round-robin contention from reset: p0, p1, p0
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    snap = grants.size();
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 2'b00, 1'b0);
    repeat (9) @(negedge clk);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    check("rr_count", grants.size() - snap, 32'd3);
    if (grants.size() >= snap + 3) begin
      check("rr_first",  grants[snap],     32'd0);
      check("rr_second", grants[snap + 1], 32'd1);
      check("rr_third",  grants[snap + 2], 32'd0);
    end else begin
      check("rr_order_short", grants.size() - snap, 32'd3);
    end

    // Fixed priority: p0 held valid starves p1
    @(posedge clk); #1;
    fp_p0_req_valid = 1'b1;
    fp_p1_req_valid = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    repeat (12) begin
      @(negedge clk);
      if (fp_p0_req_ready) cnt_a++;
      if (fp_p1_req_ready) cnt_b++;
    end
    @(posedge clk); #1;
    fp_p0_req_valid = 1'b0;
    fp_p1_req_valid = 1'b0;
    check("fp_p0_grants", cnt_a, 32'd4);
    check("fp_p1_starve", cnt_b, 32'd0);

    // Reset during the access phase of a store
    repeat (3) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b1, 32'h8, 32'h0000_0055, 2'b00, 1'b0);
    cnt_a = 0;
    @(negedge clk);
    while (!p0_req_ready && cnt_a < 20) begin
      @(negedge clk);
      cnt_a++;
    end
    check("rstacc_handshake", {31'h0, p0_req_ready}, 32'h1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rstacc_we", {31'h0, dmem_write_en}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_b = 0;
    repeat (4) begin
      @(negedge clk);
      if (p0_resp_valid || p1_resp_valid) cnt_b++;
    end
    check("rstacc_no_resp", cnt_b,           32'd0);
    check("rstacc_mem8",    {24'h0, mem[8]}, 32'h0);

    // Arbiter recovers and memory kept earlier contents
    xact(0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, rd, er, lat);
    check("post_rst_lb", rd,  32'h0000_00AA);
    check("post_rst_lat", lat, 32'd2);

    repeat (3) @(negedge clk);
    check("mon_one_ready", viol_ready, 32'd0);
    check("mon_resp_port", viol_resp,  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning 1 = round-robin between ports, 0 = fixed priority with port 0 highest.
REQ-002 Parameter ALIGN_CHK, default 1, meaning 1 = misaligned halfword/word requests are rejected with an error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 p0_req_valid / p1_req_valid  input  1  requester n presents an access.
REQ-006 p0_req_ready / p1_req_ready  output  1  arbiter accepts requester n's access this cycle.
REQ-007 p0_req_we / p1_req_we  input  1  1 = store, 0 = load.
REQ-008 p0_req_addr / p1_req_addr  input  32  byte address.
REQ-009 p0_req_wdata / p1_req_wdata  input  32  store data, LSB-aligned.
REQ-010 p0_req_size / p1_req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 p0_req_sext / p1_req_sext  input  1  sign-extend load result.
REQ-012 p0_resp_valid / p1_resp_valid  output  1  one-cycle completion pulse to requester n.
REQ-013 p0_resp_rdata / p1_resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 p0_resp_err / p1_resp_err  output  1  access rejected; qualified by resp_valid.
REQ-015 dmem_write_en  output  1  DMEM write strobe; DMEM writes on the clk edge.
REQ-016 dmem_addr, dmem_write_data  output  32 each  DMEM address and data.
REQ-017 dmem_size  output  2, dmem_sign_extend  output  1  forwarded access attributes.
REQ-018 dmem_read_data  input  32  DMEM combinational read result.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on handshake, ACCESS->RESP always, and RESP->IDLE always.
REQ-020 In IDLE, exactly one req_ready SHALL be high, on the selected valid port; all req_ready SHALL be 0 in ACCESS and RESP.
REQ-021 Selection: only one valid port -> that port; both valid with RR_EN=1 -> the port not granted last; both valid with RR_EN=0 -> port 0.
REQ-022 On handshake, the arbiter SHALL latch we/addr/wdata/size/sext and the grant id into a holding register.
REQ-023 Error condition: size=11, or ALIGN_CHK=1 with (half and addr[0]) or (word and addr[1:0]!=0).
REQ-024 In ACCESS, dmem_* SHALL be driven from the holding register, with dmem_write_en = we AND NOT error; dmem_read_data SHALL be captured at the end of ACCESS.
REQ-025 Outside ACCESS, dmem_write_en SHALL be 0 and the other dmem_* outputs SHALL hold their last values.
REQ-026 In RESP, resp_valid SHALL pulse for exactly one cycle on the granted port only, with rdata = captured data if load and no error, else 0.
REQ-027 Latency: handshake in cycle N -> DMEM access in N+1 -> resp_valid in N+2; next accept in N+3; peak throughput is 1 access per 3 cycles.
REQ-028 The round-robin pointer SHALL update only on a handshake; an erroneous request still counts as a grant.
REQ-029 Requesters SHALL hold req_* stable while valid and not ready; dropping valid before ready is legal and causes no access.

Reset
REQ-030 While rst=1: state=IDLE, rr pointer=0 (port 0 preferred first), all ready/resp_valid/resp_err/dmem_write_en=0, and rdata and holding registers=0.
REQ-031 Reset asserted in ACCESS SHALL suppress the DMEM write on that edge and discard the pending response.

Structure
REQ-032 Shared package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state typedef.
REQ-033 Sub-module dmem_align_chk (combinational size/addr -> error) SHALL be instantiated once; the FSM and arbitration SHALL remain in the top level.

Verification
REQ-034 p0 store byte addr 0 wdata 0xAA, then p0 load byte sext=1 -> p0_resp_rdata=0xFFFFFFAA, resp_err=0, resp_valid 2 cycles after handshake.
REQ-035 p0 and p1 valid simultaneously with RR_EN=1 from reset -> p0 granted first, p1 next; with RR_EN=0 and p0 held valid -> p1 starved.
REQ-036 p1 store word addr 6 -> p1_resp_err=1, dmem_write_en never high, a subsequent word load from addr 4 returns the old data.
REQ-037 p0 store half addr 4 wdata 0xBBCC, then load half sext=0 -> 0x0000BBCC; with sext=1 -> 0xFFFFBBCC.
REQ-038 size=11 request -> resp_err=1 and rdata=0; reset pulsed during ACCESS of a store -> no DMEM write and no resp_valid.
REQ-039 Throughout all scenarios: at most one req_ready per cycle, and a resp_valid pulse only on the granted port.
